ram_burst_reader: RTL

//  Read-side initiator for two_port_ram: takes a burst command (start address, word count),

---
 rtl/ram_burst_reader.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/ram_burst_reader.sv
// Burst read initiator for a 1-cycle-latency RAM: issues sequential reads and
// streams the returned words through a 3-entry buffer as a valid/ready stream.
module ram_burst_reader #(
    parameter int WIDTH = 512,
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH),
    parameter int LEN_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [AW-1:0]    ram_raddr,
    output logic             ram_read_enable,
    input  logic [WIDTH-1:0] ram_q,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // READ  | issuing reads, throttled by buffer occupancy
    // DRAIN | every read issued, emptying buffer through the m_last beat
    // DONE  | single-cycle completion pulse
    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]    raddr;
    logic [AW-1:0]    raddr_inc;
    logic [LEN_W-1:0] remaining;
    logic [LEN_W-1:0] remaining_nxt;
    logic             re;
    logic             re_nxt;
    logic             cap;
    logic             cap_last;
    logic [WIDTH-1:0] buf_data [3];
    logic             buf_last [3];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_nxt;
    logic             cmd_fire;
    logic             pop;
    logic             last_issue;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign m_valid         = (count != 2'd0);
    assign m_data          = buf_data[rd_ptr];
    assign m_last          = m_valid && buf_last[rd_ptr];
    assign ram_raddr       = raddr;
    assign ram_read_enable = re;
    assign cmd_fire        = cmd_valid && cmd_ready;
    assign pop             = m_valid && m_ready;
    assign last_issue      = re && (remaining == LEN_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = (cmd_len == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (last_issue) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (pop && m_last) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // read_enable is registered, so the issue rule is evaluated on next-cycle
    // occupancy: words buffered then plus the read going out this cycle.
    always_comb begin
        count_nxt     = count + {1'b0, cap} - {1'b0, pop};
        remaining_nxt = remaining;
        if (cmd_fire) begin
            remaining_nxt = cmd_len;
        end else if (re) begin
            remaining_nxt = remaining - LEN_W'(1);
        end
        re_nxt    = (state_nxt == S_READ) && (remaining_nxt != '0) &&
                    (({1'b0, count_nxt} + {2'b00, re}) <= 3'd2);
        raddr_inc = (raddr == AW'(DEPTH - 1)) ? '0 : raddr + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raddr     <= '0;
            remaining <= '0;
            re        <= 1'b0;
            cap       <= 1'b0;
            cap_last  <= 1'b0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 2'd0;
            for (int i = 0; i < 3; i++) begin
                buf_data[i] <= '0;
                buf_last[i] <= 1'b0;
            end
        end else begin
            remaining <= remaining_nxt;
            re        <= re_nxt;
            cap       <= re;
            cap_last  <= last_issue;
            count     <= count_nxt;
            if (cmd_fire) begin
                raddr <= cmd_addr;
            end else if (re) begin
                raddr <= raddr_inc;
            end
            if (cap) begin
                buf_data[wr_ptr] <= ram_q;
                buf_last[wr_ptr] <= cap_last;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

endmodule
